// File: rtl/sc_sync_pkg.sv
// Shared types for the Schmidl-Cox peak gate: FSM state encoding and the
// pointer-width helper used to size the sample delay line.
package sc_sync_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    SKIP,
    EMIT,
    HOLD
  } state_t;

  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sc_peak_gate_if.sv
// Ready/valid stream bundle used for the metric, sample and packet streams.
interface sc_peak_gate_if #(
  parameter int W = 32
);
  logic [W-1:0] tdata;
  logic         tlast;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, tlast, tvalid, input  tready);
  modport slave  (input  tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/sc_delay_line.sv
// Circular sample buffer: each write returns the sample written DEPTH writes
// earlier; primed rises once the buffer has been filled once.
module sc_delay_line
  import sc_sync_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         wr_en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         primed
);

  localparam int AW = ptr_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr   <= '0;
      primed <= 1'b0;
    end else if (clear) begin
      wptr   <= '0;
      primed <= 1'b0;
    end else if (wr_en) begin
      wptr <= wptr + 1'b1;
      if (wptr == AW'(DEPTH - 1)) primed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= din;
  end

  // Read-before-write at the write pointer yields the oldest stored sample.
  assign dout = mem[wptr];

endmodule

// File: rtl/sc_peak_gate.sv
// Packet gate: arms on a metric threshold crossing, finds the metric argmax
// over a SEARCH_LEN window, then emits packet_length delayed samples.
module sc_peak_gate
  import sc_sync_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int M_WIDTH    = 32,
  parameter int SEARCH_LEN = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [M_WIDTH-1:0]    threshold,
  input  logic [CNT_WIDTH-1:0]  packet_length,
  input  logic [CNT_WIDTH-1:0]  start_offset,
  input  logic [CNT_WIDTH-1:0]  holdoff,
  sc_peak_gate_if.slave         m,
  sc_peak_gate_if.slave         i,
  sc_peak_gate_if.master        o,
  output logic                  o_detect,
  output logic [M_WIDTH-1:0]    o_peak_value,
  output logic [CNT_WIDTH-1:0]  o_peak_pos
);

  state_t                 state, state_n;
  logic [CNT_WIDTH-1:0]   cnt, cnt_n;
  logic [M_WIDTH-1:0]     cand, cand_n;
  logic [CNT_WIDTH-1:0]   pos, pos_n;
  logic [CNT_WIDTH-1:0]   plen, plen_n;
  logic [CNT_WIDTH-1:0]   off, off_n;
  logic [CNT_WIDTH-1:0]   hold, hold_n;
  logic [CNT_WIDTH-1:0]   skip;
  logic                   adv, acc, upd, det_n, emit, last;
  logic [DATA_WIDTH-1:0]  dly;
  logic                   primed;
  logic                   unused_tlast;

  assign unused_tlast = m.tlast ^ i.tlast;

  // Both streams advance together; the output register gates everything.
  assign adv      = !o.tvalid || o.tready;
  assign m.tready = adv && i.tvalid;
  assign i.tready = adv && m.tvalid;
  assign acc      = adv && m.tvalid && i.tvalid;

  sc_delay_line #(.W(DATA_WIDTH), .DEPTH(SEARCH_LEN)) u_dly (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .wr_en  (acc),
    .din    (i.tdata),
    .dout   (dly),
    .primed (primed)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
      pos   <= '0;
      plen  <= '0;
      off   <= '0;
      hold  <= '0;
    end else if (clear) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
      pos   <= '0;
      plen  <= '0;
      off   <= '0;
      hold  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cand  <= cand_n;
      pos   <= pos_n;
      plen  <= plen_n;
      off   <= off_n;
      hold  <= hold_n;
    end
  end

  // cnt is reused: search index, remaining skip, remaining beats, remaining holdoff.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    pos_n   = pos;
    plen_n  = plen;
    off_n   = off;
    hold_n  = hold;
    skip    = '0;
    upd     = 1'b0;
    det_n   = 1'b0;
    emit    = 1'b0;
    last    = 1'b0;
    if (acc) begin
      case (state)
        IDLE: begin
          if (m.tdata >= threshold && packet_length != '0) begin
            plen_n  = packet_length;
            off_n   = start_offset;
            hold_n  = holdoff;
            cand_n  = m.tdata;
            pos_n   = '0;
            cnt_n   = CNT_WIDTH'(1);
            state_n = SEARCH;
          end
        end
        SEARCH: begin
          upd   = m.tdata > cand;
          if (upd) begin
            cand_n = m.tdata;
            pos_n  = cnt;
          end
          cnt_n = cnt + 1'b1;
          if (cnt == CNT_WIDTH'(SEARCH_LEN - 1)) begin
            det_n = 1'b1;
            skip  = (upd ? cnt : pos) + off;
            if (skip == '0) begin
              cnt_n   = plen;
              state_n = EMIT;
            end else begin
              cnt_n   = skip;
              state_n = SKIP;
            end
          end
        end
        SKIP: begin
          cnt_n = cnt - 1'b1;
          if (cnt == CNT_WIDTH'(1)) begin
            cnt_n   = plen;
            state_n = EMIT;
          end
        end
        EMIT: begin
          emit  = 1'b1;
          last  = cnt == CNT_WIDTH'(1);
          cnt_n = cnt - 1'b1;
          if (last) begin
            if (hold == '0) begin
              state_n = IDLE;
            end else begin
              cnt_n   = hold;
              state_n = HOLD;
            end
          end
        end
        HOLD: begin
          cnt_n = cnt - 1'b1;
          if (cnt == CNT_WIDTH'(1)) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o.tvalid     <= 1'b0;
      o.tlast      <= 1'b0;
      o.tdata      <= '0;
      o_detect     <= 1'b0;
      o_peak_value <= '0;
      o_peak_pos   <= '0;
    end else if (clear) begin
      o.tvalid     <= 1'b0;
      o.tlast      <= 1'b0;
      o.tdata      <= '0;
      o_detect     <= 1'b0;
      o_peak_value <= '0;
      o_peak_pos   <= '0;
    end else begin
      o_detect <= det_n;
      if (det_n) begin
        o_peak_value <= cand_n;
        o_peak_pos   <= pos_n;
      end
      if (emit) begin
        o.tdata  <= primed ? dly : '0;
        o.tvalid <= 1'b1;
        o.tlast  <= last;
      end else if (o.tready) begin
        o.tvalid <= 1'b0;
        o.tlast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sc_peak_gate.sv
// Table-driven bench for sc_peak_gate with an expected-beat scoreboard queue.
module tb_sc_peak_gate;

  logic        clk, reset, clear;
  logic [31:0] threshold;
  logic [15:0] packet_length, start_offset, holdoff;
  logic        o_detect;
  logic [31:0] o_peak_value;
  logic [15:0] o_peak_pos;

  sc_peak_gate_if #(.W(32)) m_if ();
  sc_peak_gate_if #(.W(32)) i_if ();
  sc_peak_gate_if #(.W(32)) o_if ();

  sc_peak_gate #(.DATA_WIDTH(32), .M_WIDTH(32), .SEARCH_LEN(8), .CNT_WIDTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .threshold     (threshold),
    .packet_length (packet_length),
    .start_offset  (start_offset),
    .holdoff       (holdoff),
    .m             (m_if),
    .i             (i_if),
    .o             (o_if),
    .o_detect      (o_detect),
    .o_peak_value  (o_peak_value),
    .o_peak_pos    (o_peak_pos)
  );

  typedef struct {
    int pat; int thr; int plen; int off; int hold; int stall; int use_clr;
    int npk; int f0; int f1; int ndet; int pv; int pp;
  } row_t;

  typedef struct { logic [31:0] d; logic l; } exp_t;

  exp_t        q[$];
  row_t        rows[9];
  int          checks, errors, beats, lasts, dets, ph;
  bit          stall_mode, prev_stall;
  logic [31:0] prev_data;
  logic [3:0]  rdy_pat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] met(input int rel, input int pat, input int p0);
    int shape [5] = '{10, 20, 50, 40, 50};
    int r;
    r = rel - p0;
    if (r >= 0 && r < 5) return 32'(shape[r]);
    if (pat == 1 && r >= 10 && r < 15) return 32'(shape[r-10]);
    if (pat == 2 && r >= 20 && r < 25) return 32'(shape[r-20]);
    return 32'd0;
  endfunction

  // Output ready: toggles 1,0,0,1 in stall mode, otherwise always ready.
  always @(posedge clk) begin
    #1;
    if (stall_mode) begin
      o_if.tready = rdy_pat[ph];
      ph = (ph + 1) % 4;
    end else begin
      o_if.tready = 1'b1;
    end
  end

  // Scoreboard monitor: every accepted output beat pops one expectation.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", o_if.tvalid, 1'b1);
        chk("stall_data", o_if.tdata, prev_data);
      end
      if (o_if.tvalid && o_if.tready) begin
        exp_t e;
        beats++;
        if (o_if.tlast) lasts++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got %0h expected no beat", o_if.tdata);
        end else begin
          e = q.pop_front();
          chk("beat_data", o_if.tdata, e.d);
          chk("beat_last", o_if.tlast, e.l);
        end
      end
      if (o_detect) dets++;
      prev_stall = o_if.tvalid && !o_if.tready;
      prev_data  = o_if.tdata;
    end
  end

  task automatic stream(input int base, input int pat, input int p0, input int n,
                        input bit gaps, input int stop_beats);
    int  idx = 0;
    int  guard = 0;
    bit  fire;
    while (idx < n) begin
      if (stop_beats > 0 && beats >= stop_beats) return;
      m_if.tdata  = met(idx, pat, p0);
      i_if.tdata  = 32'(base + idx);
      m_if.tvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_if.tvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      fire = m_if.tvalid && i_if.tvalid && m_if.tready && i_if.tready;
      @(posedge clk);
      #1;
      if (fire) idx++;
      guard++;
      if (guard > 4000) begin
        checks++;
        errors++;
        $display("FAIL stream_timeout: got %0d accepts expected %0d", idx, n);
        m_if.tvalid = 1'b0;
        i_if.tvalid = 1'b0;
        return;
      end
    end
    m_if.tvalid = 1'b0;
    i_if.tvalid = 1'b0;
  endtask

  task automatic push_pkt(input int first, input int len);
    for (int j = 0; j < len; j++) q.push_back('{d: 32'(first + j), l: (j == len - 1)});
  endtask

  task automatic restart(input bit use_clr);
    @(posedge clk);
    #1;
    if (use_clr) begin
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
    end else begin
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
    end
    q.delete();
    beats = 0; lasts = 0; dets = 0;
    @(negedge clk);
    chk("rst_tvalid", o_if.tvalid, 1'b0);
    chk("rst_tlast", o_if.tlast, 1'b0);
    chk("rst_tdata", o_if.tdata, 32'd0);
    chk("rst_detect", o_detect, 1'b0);
    chk("rst_peak_value", o_peak_value, 32'd0);
    chk("rst_peak_pos", o_peak_pos, 16'd0);
  endtask

  initial begin
    checks = 0; errors = 0; beats = 0; lasts = 0; dets = 0; ph = 0;
    stall_mode = 1'b0; prev_stall = 1'b0; prev_data = '0; rdy_pat = 4'b1001;
    reset = 1'b1; clear = 1'b0;
    threshold = 32'd16; packet_length = 16'd4; start_offset = '0; holdoff = '0;
    m_if.tdata = '0; m_if.tlast = 1'b0; m_if.tvalid = 1'b0;
    i_if.tdata = '0; i_if.tlast = 1'b0; i_if.tvalid = 1'b0;
    o_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    //          pat thr plen off hold stall clr npk  f0   f1 ndet pv pp
    rows[0] = '{0, 16, 4, 0, 0,  0, 0, 1, 102, 0,   1, 50, 1};
    rows[1] = '{0, 16, 4, 3, 0,  0, 1, 1, 105, 0,   1, 50, 1};
    rows[2] = '{0, 16, 4, 0, 0,  1, 0, 1, 102, 0,   1, 50, 1};
    rows[3] = '{1, 16, 4, 0, 20, 0, 0, 1, 102, 0,   1, 50, 1};
    rows[4] = '{2, 16, 4, 0, 0,  0, 1, 2, 102, 122, 2, 50, 1};
    rows[5] = '{2, 16, 4, 0, 20, 0, 0, 1, 102, 0,   1, 50, 1};
    rows[6] = '{0, 16, 0, 0, 0,  0, 1, 0, 0,   0,   0, 0,  0};
    rows[7] = '{0, 50, 4, 0, 0,  0, 0, 1, 102, 0,   1, 50, 0};
    rows[8] = '{0, 51, 4, 0, 0,  0, 0, 0, 0,   0,   0, 0,  0};

    for (int r = 0; r < 9; r++) begin
      restart(rows[r].use_clr != 0);
      threshold     = 32'(rows[r].thr);
      packet_length = 16'(rows[r].plen);
      start_offset  = 16'(rows[r].off);
      holdoff       = 16'(rows[r].hold);
      if (rows[r].npk > 0) push_pkt(rows[r].f0, rows[r].plen);
      if (rows[r].npk > 1) push_pkt(rows[r].f1, rows[r].plen);
      stall_mode = rows[r].stall != 0;
      stream(0, rows[r].pat, 100, 160, rows[r].stall != 0, 0);
      stall_mode = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      chk("pending_beats", q.size(), 0);
      chk("tlast_count", lasts, rows[r].npk);
      chk("detect_count", dets, rows[r].ndet);
      chk("peak_value", o_peak_value, 32'(rows[r].pv));
      chk("peak_pos", o_peak_pos, 16'(rows[r].pp));
    end

    // Asynchronous reset mid-packet, then a fresh packet after re-priming.
    restart(1'b0);
    threshold = 32'd16; packet_length = 16'd4; start_offset = '0; holdoff = '0;
    push_pkt(102, 4);
    stream(0, 0, 100, 160, 1'b0, 2);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_tvalid", o_if.tvalid, 1'b0);
    chk("async_rst_tlast", o_if.tlast, 1'b0);
    chk("truncated_beats", q.size(), 2);
    chk("no_tlast_truncated", lasts, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    beats = 0; lasts = 0; dets = 0;
    push_pkt(242, 4);
    stream(200, 0, 40, 100, 1'b0, 0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("repacket_pending", q.size(), 0);
    chk("repacket_tlast", lasts, 1);
    chk("repacket_detect", dets, 1);
    chk("repacket_peak_value", o_peak_value, 32'd50);
    chk("repacket_peak_pos", o_peak_pos, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
